// File: rtl/mandelbrot_pkg.sv
// Shared constants and types for the Mandelbrot datapath.
package mandelbrot_pkg;

    localparam int PIXEL_DATA_WIDTH   = 10;
    localparam int ENGINE_DATA_WIDTH  = 25;
    localparam int ENGINE_FRACT_WIDTH = 20;
    localparam int ITERATIONS_WIDTH   = 6;
    localparam int H_RES              = 640;
    localparam int V_RES              = 480;

    // Pixel distributor frame state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } distributor_state_t;

endpackage

// File: rtl/pixel_raster_counter.sv
// Raster-order (x,y) counter: x runs fastest, y steps when x wraps.
// 'last' flags the final pixel of the frame.
module pixel_raster_counter #(
    parameter int PW    = 10,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [PW-1:0] x,
    output logic [PW-1:0] y,
    output logic          last
);

    localparam logic [PW-1:0] X_MAX = PW'(H_RES - 1);
    localparam logic [PW-1:0] Y_MAX = PW'(V_RES - 1);

    logic [PW-1:0] x_q, x_d;
    logic [PW-1:0] y_q, y_d;

    // Next raster position: clear wins over advance; y wraps with the frame.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear) begin
            x_d = '0;
            y_d = '0;
        end else if (advance) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + PW'(1);
            end else begin
                x_d = x_q + PW'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Raster position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/pixel_distributor.sv
// Scans the frame in raster order and hands one pixel coordinate per cycle
// to a free engine slot, round-robin. Latches the view parameters at frame
// start so every engine sees the same view for the whole frame.
module pixel_distributor
    import mandelbrot_pkg::*;
#(
    parameter int NUM_ENGINES       = 4,
    parameter int PIXEL_DATA_WIDTH  = mandelbrot_pkg::PIXEL_DATA_WIDTH,
    parameter int ENGINE_DATA_WIDTH = mandelbrot_pkg::ENGINE_DATA_WIDTH,
    parameter int ITERATIONS_WIDTH  = mandelbrot_pkg::ITERATIONS_WIDTH,
    parameter int H_RES             = mandelbrot_pkg::H_RES,
    parameter int V_RES             = mandelbrot_pkg::V_RES
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic signed [ENGINE_DATA_WIDTH-1:0]       x_offset_in,
    input  logic signed [ENGINE_DATA_WIDTH-1:0]       y_offset_in,
    input  logic        [2:0]                         zoom_in,
    input  logic        [ITERATIONS_WIDTH-1:0]        iterations_max_in,
    input  logic        [NUM_ENGINES-1:0]             take,
    output logic        [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] x0,
    output logic        [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] y0,
    output logic        [NUM_ENGINES-1:0]             px_valid,
    output logic signed [ENGINE_DATA_WIDTH-1:0]       x_offset,
    output logic signed [ENGINE_DATA_WIDTH-1:0]       y_offset,
    output logic        [2:0]                         zoom,
    output logic        [ITERATIONS_WIDTH-1:0]        iterations_max,
    output logic                                      busy,
    output logic                                      frame_done
);

    localparam int PW    = PIXEL_DATA_WIDTH;
    localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    distributor_state_t state_q, state_d;

    logic [PTR_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [NUM_ENGINES-1:0]             valid_q, valid_d;
    logic [NUM_ENGINES-1:0][PW-1:0]     x0_q, x0_d;
    logic [NUM_ENGINES-1:0][PW-1:0]     y0_q, y0_d;
    logic signed [ENGINE_DATA_WIDTH-1:0] x_offset_q, x_offset_d;
    logic signed [ENGINE_DATA_WIDTH-1:0] y_offset_q, y_offset_d;
    logic [2:0]                         zoom_q, zoom_d;
    logic [ITERATIONS_WIDTH-1:0]        iter_max_q, iter_max_d;
    logic                               busy_q, busy_d;
    logic                               frame_done_q, frame_done_d;

    logic [PW-1:0]    raster_x_s;
    logic [PW-1:0]    raster_y_s;
    logic             raster_last_s;
    logic             raster_clear_s;
    logic             raster_adv_s;
    logic             found_s;
    logic [PTR_W-1:0] sel_s;
    logic             all_clear_s;

    pixel_raster_counter #(
        .PW    (PW),
        .H_RES (H_RES),
        .V_RES (V_RES)
    ) u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (raster_clear_s),
        .advance (raster_adv_s),
        .x       (raster_x_s),
        .y       (raster_y_s),
        .last    (raster_last_s)
    );

    // Nothing left in any slot once this edge's takes are applied.
    assign all_clear_s    = ((valid_q & ~take) == '0);
    assign raster_clear_s = (state_q == IDLE) && start;
    assign raster_adv_s   = (state_q == RUN) && found_s;

    // Round-robin search for the first empty slot at or above rr_ptr.
    // Only slots empty at the start of the cycle qualify, so a slot taken
    // on this edge is refilled no earlier than the next one.
    always_comb begin : sel_search
        logic [PTR_W:0] sum_v;
        sum_v   = '0;
        found_s = 1'b0;
        sel_s   = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            sum_v = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            sum_v = (sum_v >= (PTR_W+1)'(NUM_ENGINES)) ? sum_v - (PTR_W+1)'(NUM_ENGINES) : sum_v;
            if (!found_s && !valid_q[sum_v[PTR_W-1:0]]) begin
                found_s = 1'b1;
                sel_s   = sum_v[PTR_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DRAIN after the last
    // pixel is loaded, DRAIN -> IDLE when every slot has been taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? RUN : IDLE;
            RUN:     state_d = (found_s && raster_last_s) ? DRAIN : RUN;
            DRAIN:   state_d = all_clear_s ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs, registered so they line up with the state register.
    always_comb begin
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_q == DRAIN) && all_clear_s;
    end

    // Slot and parameter datapath: takes clear valid bits, RUN refills one
    // empty slot per edge, IDLE latches the frame parameters on start.
    always_comb begin
        valid_d    = valid_q & ~take;
        x0_d       = x0_q;
        y0_d       = y0_q;
        rr_ptr_d   = rr_ptr_q;
        x_offset_d = x_offset_q;
        y_offset_d = y_offset_q;
        zoom_d     = zoom_q;
        iter_max_d = iter_max_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    x_offset_d = x_offset_in;
                    y_offset_d = y_offset_in;
                    zoom_d     = zoom_in;
                    iter_max_d = iterations_max_in;
                    rr_ptr_d   = '0;
                end else begin
                    rr_ptr_d   = rr_ptr_q;
                end
            end
            RUN: begin
                if (found_s) begin
                    x0_d[sel_s]    = raster_x_s;
                    y0_d[sel_s]    = raster_y_s;
                    valid_d[sel_s] = 1'b1;
                    rr_ptr_d       = (sel_s == PTR_W'(NUM_ENGINES - 1)) ? '0 : sel_s + PTR_W'(1);
                end else begin
                    rr_ptr_d       = rr_ptr_q;
                end
            end
            DRAIN:   rr_ptr_d = rr_ptr_q;
            default: rr_ptr_d = rr_ptr_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot, pointer, parameter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            valid_q      <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            x_offset_q   <= '0;
            y_offset_q   <= '0;
            zoom_q       <= '0;
            iter_max_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            valid_q      <= valid_d;
            x0_q         <= x0_d;
            y0_q         <= y0_d;
            x_offset_q   <= x_offset_d;
            y_offset_q   <= y_offset_d;
            zoom_q       <= zoom_d;
            iter_max_q   <= iter_max_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign x0             = x0_q;
    assign y0             = y0_q;
    assign px_valid       = valid_q;
    assign x_offset       = x_offset_q;
    assign y_offset       = y_offset_q;
    assign zoom           = zoom_q;
    assign iterations_max = iter_max_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_pixel_distributor.sv
// Bench for pixel_distributor: a 4-slot full-size instance for reset, fill
// order and mid-frame reset, and a 2-slot 4x2 instance for a complete frame.
module tb_pixel_distributor;

    logic clk;
    int   checks;
    int   errors;

    // ---------------- full-size instance (N=4, 640x480) ----------------
    logic         b_reset, b_start;
    logic [24:0]  b_xoff_in, b_yoff_in;
    logic [2:0]   b_zoom_in;
    logic [5:0]   b_iter_in;
    logic [3:0]   b_take;
    logic [39:0]  b_x0, b_y0;
    logic [3:0]   b_valid;
    logic [24:0]  b_xoff, b_yoff;
    logic [2:0]   b_zoom;
    logic [5:0]   b_iter;
    logic         b_busy, b_done;

    pixel_distributor dut_big (
        .clk(clk), .reset(b_reset), .start(b_start),
        .x_offset_in(b_xoff_in), .y_offset_in(b_yoff_in),
        .zoom_in(b_zoom_in), .iterations_max_in(b_iter_in), .take(b_take),
        .x0(b_x0), .y0(b_y0), .px_valid(b_valid),
        .x_offset(b_xoff), .y_offset(b_yoff), .zoom(b_zoom),
        .iterations_max(b_iter), .busy(b_busy), .frame_done(b_done)
    );

    // ---------------- small instance (N=2, 4x2) ----------------
    logic         s_reset, s_start;
    logic [24:0]  s_xoff_in, s_yoff_in;
    logic [2:0]   s_zoom_in;
    logic [5:0]   s_iter_in;
    logic [1:0]   s_take;
    logic [19:0]  s_x0, s_y0;
    logic [1:0]   s_valid;
    logic [24:0]  s_xoff, s_yoff;
    logic [2:0]   s_zoom;
    logic [5:0]   s_iter;
    logic         s_busy, s_done;

    pixel_distributor #(.NUM_ENGINES(2), .H_RES(4), .V_RES(2)) dut_small (
        .clk(clk), .reset(s_reset), .start(s_start),
        .x_offset_in(s_xoff_in), .y_offset_in(s_yoff_in),
        .zoom_in(s_zoom_in), .iterations_max_in(s_iter_in), .take(s_take),
        .x0(s_x0), .y0(s_y0), .px_valid(s_valid),
        .x_offset(s_xoff), .y_offset(s_yoff), .zoom(s_zoom),
        .iterations_max(s_iter), .busy(s_busy), .frame_done(s_done)
    );

    // Vector record: inputs for one edge and the outputs expected after it.
    typedef struct {
        logic       start;
        logic [1:0] take;
        logic       chg;
        logic [1:0] valid;
        logic [9:0] xs0, ys0, xs1, ys1;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[11];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Frame with takes issued as soon as a slot is valid (one pixel/cycle).
        //          start take  chg  valid xs0    ys0    xs1    ys1    busy done
        vecs[0]  = '{1'b1, 2'b00, 1'b0, 2'b00, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 2'b01, 10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 1'b0, 2'b10, 10'd0, 10'd0, 10'd1, 10'd0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 2'b01, 10'd2, 10'd0, 10'd1, 10'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 1'b1, 2'b10, 10'd2, 10'd0, 10'd3, 10'd0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 2'b10, 1'b0, 2'b01, 10'd0, 10'd1, 10'd3, 10'd0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 2'b01, 1'b0, 2'b10, 10'd0, 10'd1, 10'd1, 10'd1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'b10, 1'b0, 2'b01, 10'd2, 10'd1, 10'd1, 10'd1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 2'b10, 10'd2, 10'd1, 10'd3, 10'd1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 2'b00, 10'd2, 10'd1, 10'd3, 10'd1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 2'b00, 10'd2, 10'd1, 10'd3, 10'd1, 1'b0, 1'b0};

        b_reset = 1'b1; b_start = 1'b0; b_take = 4'b1111;
        b_xoff_in = 25'h1F00001; b_yoff_in = 25'h0012345; b_zoom_in = 3'd5; b_iter_in = 6'd33;
        s_reset = 1'b1; s_start = 1'b0; s_take = 2'b11;
        s_xoff_in = 25'h1F00001; s_yoff_in = 25'h0012345; s_zoom_in = 3'd5; s_iter_in = 6'd33;

        // Reset for two cycles with all takes high.
        tick();
        tick();
        chk("rst_valid", 64'(b_valid), 64'd0);
        chk("rst_x0",    64'(b_x0),    64'd0);
        chk("rst_y0",    64'(b_y0),    64'd0);
        chk("rst_busy",  64'(b_busy),  64'd0);
        chk("rst_done",  64'(b_done),  64'd0);
        chk("rst_params", {b_xoff, b_yoff, b_zoom, b_iter}, 64'd0);
        chk("rst_small", {s_valid, s_x0, s_y0, s_busy, s_done}, 64'd0);
        b_reset = 1'b0; s_reset = 1'b0;
        b_take = 4'b0000; s_take = 2'b00;

        // Fill order: start, never take.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("fill_busy",  64'(b_busy),  64'd1);
        chk("fill_valid0", 64'(b_valid), 64'd0);
        chk("fill_params", {b_xoff, b_yoff, b_zoom, b_iter}, {25'h1F00001, 25'h0012345, 3'd5, 6'd33});
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("fill_valid", 64'(b_valid), 64'((4'b0001 << (j + 1)) - 4'b0001));
            chk("fill_x", 64'(b_x0[j*10 +: 10]), 64'(j));
            chk("fill_y", 64'(b_y0[j*10 +: 10]), 64'd0);
        end
        tick();
        tick();
        chk("stall_valid", 64'(b_valid), 64'hF);
        chk("stall_busy",  64'(b_busy),  64'd1);
        chk("stall_x3",    64'(b_x0[39:30]), 64'd3);

        // Take slot 0: empty for one cycle, then refilled with (4,0).
        b_take = 4'b0001;
        tick();
        b_take = 4'b0000;
        chk("take_clear", 64'(b_valid), 64'hE);
        tick();
        chk("refill_valid", 64'(b_valid), 64'hF);
        chk("refill_x0", 64'(b_x0[9:0]), 64'd4);

        // Reset mid-frame, then restart: first fill lands in slot 0.
        b_reset = 1'b1;
        tick();
        b_reset = 1'b0;
        chk("mrst_out", {b_valid, b_x0, b_busy, b_done}, 64'd0);
        chk("mrst_y0", 64'(b_y0), 64'd0);
        chk("mrst_params", {b_xoff, b_yoff, b_zoom, b_iter}, 64'd0);
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        tick();
        chk("restart_valid", 64'(b_valid), 64'h1);
        chk("restart_xy", {b_x0[9:0], b_y0[9:0]}, 64'd0);

        // Full frame on the small instance.
        for (int i = 0; i < 11; i++) begin
            s_start = vecs[i].start;
            s_take  = vecs[i].take;
            if (vecs[i].chg) begin
                s_xoff_in = 25'h0000007; s_yoff_in = 25'h1555555; s_zoom_in = 3'd2; s_iter_in = 6'd9;
            end
            tick();
            s_start = 1'b0;
            s_take  = 2'b00;
            chk($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(vecs[i].valid));
            chk($sformatf("vec%0d_slot0", i), {s_x0[9:0], s_y0[9:0]}, {vecs[i].xs0, vecs[i].ys0});
            chk($sformatf("vec%0d_slot1", i), {s_x0[19:10], s_y0[19:10]}, {vecs[i].xs1, vecs[i].ys1});
            chk($sformatf("vec%0d_busy", i), 64'(s_busy), 64'(vecs[i].busy));
            chk($sformatf("vec%0d_done", i), 64'(s_done), 64'(vecs[i].done));
        end
        chk("hold_params", {s_xoff, s_yoff, s_zoom, s_iter}, {25'h1F00001, 25'h0012345, 3'd5, 6'd33});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
